alu_cmd_issuer: RTL and testbench
=================================

# alu_cmd_issuer

Sequential initiator for the combinational ALU. It accepts operation commands (a, b, opcode) over a valid/ready handshake and buffers them in a small FIFO. It drives them one at a time into the ALU through registered operand/opcode outputs, then captures the ALU result and {N,Z,C,V} flags. Each completed command is returned on a valid/ready response channel, and a sticky status-flag register plus a completed-operation counter are maintained for the rest of the datapath.

## Interface
- N, default 4: operand/result width; must match the ALU instance width.
- DEPTH, default 4: command FIFO entries; power of two, ≥2.
- clk  in  1  system clock, rising-edge.
- rst_n  in  1  reset, asynchronous, active-low.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  FIFO can accept; equals !full.
- cmd_a, cmd_b  in  N  operands.
- cmd_op  in  3  opcode.
- alu_a, alu_b  out  N  registered operands to ALU.
- alu_op  out  3  registered opcode to ALU.
- alu_result  in  N  ALU Result.
- alu_n, alu_z, alu_c, alu_v  in  1 each  ALU flags.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  consumer accepts response.
- rsp_result  out  N  captured result.
- rsp_flags  out  4  captured {N,Z,C,V}.
- rsp_err  out  1  command had an illegal opcode.
- flags_q  out  4  sticky {N,Z,C,V} of the last legal operation.
- op_count  out  8  number of legal operations completed, wrapping.

## Operation
- Legal opcodes: ADD 3'b000, SUB 3'b001, AND 3'b010, OR 3'b011, XOR 3'b111. Codes 100, 101 and 110 are illegal.
- Push: cmd_valid && cmd_ready at an edge writes {a,b,op} at the FIFO tail.
- FSM states: IDLE, EXEC, RESP.
- IDLE: if the FIFO is non-empty, load alu_a/alu_b/alu_op from the head and pop. Next state EXEC.
- EXEC: exactly one cycle, with ALU inputs stable. At the closing edge:
  - capture rsp_result/rsp_flags from the ALU;
  - set rsp_err = illegal(alu_op), and for an illegal op force rsp_result=0 and rsp_flags=0;
  - set rsp_valid=1;
  - for a legal op only, update flags_q and increment op_count (255→0).
  - Next state RESP.
- RESP: hold the rsp_* outputs stable while rsp_valid && !rsp_ready. On the handshake edge, clear rsp_valid. If the FIFO is non-empty, load and pop the head in that same edge and go to EXEC; otherwise go to IDLE.
- alu_a/alu_b/alu_op hold their last value when not being loaded.
- Responses leave in strict command order. No command is dropped or duplicated.

## Timing
- Reset values: cmd_ready=1 (FIFO empty), alu_a=alu_b=0, alu_op=000, rsp_valid=0, rsp_result=0, rsp_flags=0, rsp_err=0, flags_q=0, op_count=0. FSM is in IDLE.
- Latency with an empty FIFO in IDLE and rsp_ready=1:
  - command accepted at edge E0;
  - popped and ALU loaded at E1;
  - captured at E2, rsp_valid high after E2;
  - response retired at E3.
- No bypass path: a command pushed in IDLE waits for the next edge.
- Throughput with rsp_ready held high: one response every 2 cycles.
- Simultaneous push and pop on a non-full FIFO: both occur, and the count is unchanged.
- Full: cmd_ready is low during the cycle the count equals DEPTH. A push attempted while full is ignored.
- Wrap-around: FIFO pointers are log2(DEPTH) bits and wrap naturally. Full/empty are resolved with an explicit count register.
- Reset mid-operation: all state, FIFO contents and any in-flight or pending response are discarded immediately, asynchronously.
- The ALU is purely combinational, so inputs registered at one edge are valid for capture at the next edge.

## Structure
- Package alu_pkg:
  - opcode localparams (OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR);
  - flag bit indices (FLAG_N=3, FLAG_Z=2, FLAG_C=1, FLAG_V=0);
  - FSM state enum {IDLE, EXEC, RESP};
  - function is_legal_op.
  The ALU is updated to import the same opcode constants.
- Sub-module alu_cmd_fifo: synchronous FIFO, parameters W and DEPTH, ports push/pop/din/dout/full/empty, clk/rst_n. The issuer instantiates it with W = 2N+3.

## Test plan
- ADD a=0111, b=0001 → rsp_result=1000, rsp_flags=1001 (N=1, V=1), rsp_err=0, op_count=1. rsp_valid appears exactly 2 edges after acceptance.
- ADD a=1111, b=0001, then SUB a=0011, b=0011 → responses in order: 0000 with flags Z=1, C=1; then 0000 with Z=1, N=0, V=0. flags_q ends with Z=1.
- Illegal op 3'b101, a=0101, b=0011 → rsp_err=1, rsp_result=0000, rsp_flags=0000. flags_q and op_count are unchanged.
- Hold rsp_ready=0 and issue 6 commands back-to-back:
  - exactly DEPTH+1=5 are accepted, then cmd_ready=0;
  - rsp_* stays stable;
  - after releasing rsp_ready, all 5 retire in order, one every 2 cycles.
- Assert rst_n low while in EXEC with 3 commands queued → all outputs return to reset values immediately, and no stale response appears after release.
- Issue 260 legal ops → op_count wraps and reads 4 at the end.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcodes, flag bit positions, issuer FSM states.
package alu_pkg;

  localparam int unsigned OP_W   = 3;
  localparam int unsigned FLAG_W = 4;

  localparam logic [OP_W-1:0] OP_ADD = 3'b000;
  localparam logic [OP_W-1:0] OP_SUB = 3'b001;
  localparam logic [OP_W-1:0] OP_AND = 3'b010;
  localparam logic [OP_W-1:0] OP_OR  = 3'b011;
  localparam logic [OP_W-1:0] OP_XOR = 3'b111;

  localparam int unsigned FLAG_N = 3;
  localparam int unsigned FLAG_Z = 2;
  localparam int unsigned FLAG_C = 1;
  localparam int unsigned FLAG_V = 0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } issuer_state_t;

  function automatic logic is_legal_op(input logic [OP_W-1:0] op);
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR: return 1'b1;
      default:                               return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/alu.sv
// Combinational ALU: ADD/SUB/AND/OR/XOR with {N,Z,C,V}; C on SUB means no borrow.
module alu
  import alu_pkg::*;
#(
  parameter int unsigned N = 4
) (
  input  logic [N-1:0]    i_a,
  input  logic [N-1:0]    i_b,
  input  logic [OP_W-1:0] i_op,
  output logic [N-1:0]    o_result,
  output logic            o_n,
  output logic            o_z,
  output logic            o_c,
  output logic            o_v
);

  logic [N:0] w_sum;

  always_comb begin
    w_sum    = '0;
    o_result = '0;
    o_c      = 1'b0;
    o_v      = 1'b0;
    case (i_op)
      OP_ADD: begin
        w_sum    = {1'b0, i_a} + {1'b0, i_b};
        o_result = w_sum[N-1:0];
        o_c      = w_sum[N];
        o_v      = (i_a[N-1] == i_b[N-1]) && (o_result[N-1] != i_a[N-1]);
      end
      OP_SUB: begin
        w_sum    = {1'b0, i_a} + {1'b0, ~i_b} + (N+1)'(1);
        o_result = w_sum[N-1:0];
        o_c      = w_sum[N];
        o_v      = (i_a[N-1] != i_b[N-1]) && (o_result[N-1] != i_a[N-1]);
      end
      OP_AND:  o_result = i_a & i_b;
      OP_OR:   o_result = i_a | i_b;
      OP_XOR:  o_result = i_a ^ i_b;
      default: o_result = '0;
    endcase
  end

  assign o_n = o_result[N-1];
  assign o_z = (o_result == '0);

endmodule

// File: rtl/alu_cmd_fifo.sv
// Synchronous command FIFO; full/empty come from an explicit occupancy count.
module alu_cmd_fifo #(
  parameter int unsigned W     = 11,
  parameter int unsigned DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          w_do_push;
  logic          w_do_pop;

  assign w_do_push = push && !full;
  assign w_do_pop  = pop && !empty;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= din;
  end

  assign dout  = r_mem[r_rd_ptr];
  assign full  = (r_count == CW'(DEPTH));
  assign empty = (r_count == '0);

endmodule

// File: rtl/alu_cmd_issuer.sv
// Buffers ALU commands, issues them one at a time, returns results in order
// and keeps sticky flags plus a completed-operation counter.
module alu_cmd_issuer
  import alu_pkg::*;
#(
  parameter int unsigned N     = 4,
  parameter int unsigned DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [N-1:0]      cmd_a,
  input  logic [N-1:0]      cmd_b,
  input  logic [OP_W-1:0]   cmd_op,
  output logic [N-1:0]      alu_a,
  output logic [N-1:0]      alu_b,
  output logic [OP_W-1:0]   alu_op,
  input  logic [N-1:0]      alu_result,
  input  logic              alu_n,
  input  logic              alu_z,
  input  logic              alu_c,
  input  logic              alu_v,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [N-1:0]      rsp_result,
  output logic [FLAG_W-1:0] rsp_flags,
  output logic              rsp_err,
  output logic [FLAG_W-1:0] flags_q,
  output logic [7:0]        op_count
);

  localparam int unsigned W = 2 * N + OP_W;

  logic [W-1:0]      w_din;
  logic [W-1:0]      w_dout;
  logic              w_full;
  logic              w_empty;
  logic              w_push;
  logic              w_pop;
  logic              w_load;
  logic              w_capture;
  logic              w_retire;
  logic              w_legal;
  logic [FLAG_W-1:0] w_alu_flags;

  issuer_state_t r_state;
  issuer_state_t w_state_nxt;

  logic [N-1:0]      r_alu_a;
  logic [N-1:0]      r_alu_b;
  logic [OP_W-1:0]   r_alu_op;
  logic              r_rsp_valid;
  logic [N-1:0]      r_rsp_result;
  logic [FLAG_W-1:0] r_rsp_flags;
  logic              r_rsp_err;
  logic [FLAG_W-1:0] r_flags_q;
  logic [7:0]        r_op_count;

  assign w_din     = {cmd_a, cmd_b, cmd_op};
  assign w_push    = cmd_valid && !w_full;
  assign w_pop     = w_load;
  assign cmd_ready = !w_full;

  alu_cmd_fifo #(
    .W     (W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (w_push),
    .pop   (w_pop),
    .din   (w_din),
    .dout  (w_dout),
    .full  (w_full),
    .empty (w_empty)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  // RESP always has rsp_valid set, so rsp_ready alone completes the handshake.
  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_capture   = 1'b0;
    w_retire    = 1'b0;
    case (r_state)
      IDLE: begin
        if (!w_empty) begin
          w_load      = 1'b1;
          w_state_nxt = EXEC;
        end
      end
      EXEC: begin
        w_capture   = 1'b1;
        w_state_nxt = RESP;
      end
      RESP: begin
        if (rsp_ready) begin
          w_retire = 1'b1;
          if (!w_empty) begin
            w_load      = 1'b1;
            w_state_nxt = EXEC;
          end else begin
            w_state_nxt = IDLE;
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    w_alu_flags         = '0;
    w_alu_flags[FLAG_N] = alu_n;
    w_alu_flags[FLAG_Z] = alu_z;
    w_alu_flags[FLAG_C] = alu_c;
    w_alu_flags[FLAG_V] = alu_v;
  end

  assign w_legal = is_legal_op(r_alu_op);

  // Illegal ops return zeroed data and leave the sticky state untouched.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_alu_a      <= '0;
      r_alu_b      <= '0;
      r_alu_op     <= '0;
      r_rsp_valid  <= 1'b0;
      r_rsp_result <= '0;
      r_rsp_flags  <= '0;
      r_rsp_err    <= 1'b0;
      r_flags_q    <= '0;
      r_op_count   <= '0;
    end else begin
      if (w_load) {r_alu_a, r_alu_b, r_alu_op} <= w_dout;
      if (w_capture) begin
        r_rsp_valid  <= 1'b1;
        r_rsp_err    <= !w_legal;
        r_rsp_result <= w_legal ? alu_result : '0;
        r_rsp_flags  <= w_legal ? w_alu_flags : '0;
        if (w_legal) begin
          r_flags_q  <= w_alu_flags;
          r_op_count <= r_op_count + 8'(1);
        end
      end else if (w_retire) begin
        r_rsp_valid <= 1'b0;
      end
    end
  end

  assign alu_a      = r_alu_a;
  assign alu_b      = r_alu_b;
  assign alu_op     = r_alu_op;
  assign rsp_valid  = r_rsp_valid;
  assign rsp_result = r_rsp_result;
  assign rsp_flags  = r_rsp_flags;
  assign rsp_err    = r_rsp_err;
  assign flags_q    = r_flags_q;
  assign op_count   = r_op_count;

endmodule

// File: tb/tb_alu_cmd_issuer.sv
// Bench for alu_cmd_issuer driving a real ALU; responses checked via scoreboard.
module tb_alu_cmd_issuer;
  import alu_pkg::*;

  localparam int unsigned N     = 4;
  localparam int unsigned DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [3:0] cmd_a = '0, cmd_b = '0;
  logic [2:0] cmd_op = '0;
  logic [3:0] alu_a, alu_b, alu_result;
  logic [2:0] alu_op;
  logic       alu_n, alu_z, alu_c, alu_v;
  logic       rsp_valid;
  logic       rsp_ready = 1'b0;
  logic [3:0] rsp_result, rsp_flags, flags_q;
  logic       rsp_err;
  logic [7:0] op_count;

  always #5 clk = ~clk;

  alu_cmd_issuer #(.N(N), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_op(cmd_op),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .alu_result(alu_result), .alu_n(alu_n), .alu_z(alu_z), .alu_c(alu_c), .alu_v(alu_v),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_result(rsp_result), .rsp_flags(rsp_flags), .rsp_err(rsp_err),
    .flags_q(flags_q), .op_count(op_count)
  );

  alu #(.N(N)) u_alu (
    .i_a(alu_a), .i_b(alu_b), .i_op(alu_op),
    .o_result(alu_result), .o_n(alu_n), .o_z(alu_z), .o_c(alu_c), .o_v(alu_v)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [3:0] res;
    logic [3:0] flg;
    logic       err;
    logic [3:0] fq;
    logic [7:0] cnt;
  } sb_t;

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic [2:0] op;
    logic [3:0] res;
    logic [3:0] flg;
    logic       err;
  } vec_t;

  sb_t        sb[$];
  int         retire_cyc[$];
  logic [3:0] m_fq = '0;
  logic [7:0] m_cnt = '0;
  vec_t       vecs[10];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // Independent reference: integer arithmetic, C = no borrow on SUB.
  task automatic model(input logic [3:0] a, input logic [3:0] b, input logic [2:0] op,
                       output logic [3:0] res, output logic [3:0] flg, output logic err);
    int ua, ub, sa, sbv, r, sr;
    logic c, v;
    ua = int'(a); ub = int'(b);
    sa = a[3] ? ua - 16 : ua;
    sbv = b[3] ? ub - 16 : ub;
    r = 0; c = 1'b0; v = 1'b0; err = 1'b0;
    case (op)
      3'b000: begin r = ua + ub; c = (r > 15); sr = sa + sbv; v = (sr > 7) || (sr < -8); end
      3'b001: begin r = ua - ub; c = (ua >= ub); sr = sa - sbv; v = (sr > 7) || (sr < -8); end
      3'b010: r = ua & ub;
      3'b011: r = ua | ub;
      3'b111: r = ua ^ ub;
      default: err = 1'b1;
    endcase
    res = err ? 4'b0 : r[3:0];
    flg = err ? 4'b0 : {res[3], (res == 4'b0), c, v};
  endtask

  task automatic push_entry(input logic [3:0] res, input logic [3:0] flg, input logic err);
    sb_t e;
    if (!err) begin
      m_fq = flg;
      m_cnt = m_cnt + 8'd1;
    end
    e.res = res; e.flg = flg; e.err = err; e.fq = m_fq; e.cnt = m_cnt;
    sb.push_back(e);
  endtask

  // Called just after a rising edge; returns just after the next one.
  task automatic try_send(input logic [3:0] a, input logic [3:0] b, input logic [2:0] op,
                          input logic [3:0] res, input logic [3:0] flg, input logic err,
                          output bit acc);
    cmd_a = a; cmd_b = b; cmd_op = op; cmd_valid = 1'b1;
    @(negedge clk);
    acc = cmd_ready;
    if (acc) push_entry(res, flg, err);
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
  endtask

  task automatic send(input logic [3:0] a, input logic [3:0] b, input logic [2:0] op,
                      input logic [3:0] res, input logic [3:0] flg, input logic err);
    bit acc;
    int k;
    acc = 1'b0;
    k = 0;
    while (!acc && k < 40) begin
      try_send(a, b, op, res, flg, err, acc);
      k++;
    end
    checks++;
    if (!acc) begin
      errors++;
      $display("FAIL send_timeout: got cmd_ready 0 expected 1 within 40 cycles");
    end
  endtask

  task automatic send_model(input logic [3:0] a, input logic [3:0] b, input logic [2:0] op);
    logic [3:0] res, flg;
    logic err;
    model(a, b, op, res, flg, err);
    send(a, b, op, res, flg, err);
  endtask

  task automatic drain(input int budget);
    int k;
    k = 0;
    while ((sb.size() != 0 || rsp_valid) && k < budget) begin
      @(posedge clk);
      #1;
      k++;
    end
    checks++;
    if (k >= budget) begin
      errors++;
      $display("FAIL drain_timeout: got %0d pending expected 0", sb.size());
    end
  endtask

  function automatic logic [2:0] rand_legal_op();
    logic [2:0] ops[5];
    ops = '{3'b000, 3'b001, 3'b010, 3'b011, 3'b111};
    return ops[$urandom_range(0, 4)];
  endfunction

  // Response monitor: every cycle a response is presented it must match the head.
  always @(negedge clk) begin : mon
    sb_t e;
    if (rst_n && rsp_valid) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_rsp: got result %0h flags %0h expected no response", rsp_result, rsp_flags);
      end else begin
        e = sb[0];
        check("rsp{res,flg,err,fq,cnt}",
              64'({rsp_result, rsp_flags, rsp_err, flags_q, op_count}),
              64'({e.res, e.flg, e.err, e.fq, e.cnt}));
        if (rsp_ready) begin
          void'(sb.pop_front());
          retire_cyc.push_back(cyc);
        end
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin : main
    bit acc;
    int acc_cnt;
    logic [3:0] a, b, res, flg;
    logic [2:0] op;
    logic err;

    vecs[0] = '{4'b0111, 4'b0001, 3'b000, 4'b1000, 4'b1001, 1'b0};
    vecs[1] = '{4'b1111, 4'b0001, 3'b000, 4'b0000, 4'b0110, 1'b0};
    vecs[2] = '{4'b0011, 4'b0011, 3'b001, 4'b0000, 4'b0110, 1'b0};
    vecs[3] = '{4'b0101, 4'b0011, 3'b101, 4'b0000, 4'b0000, 1'b1};
    vecs[4] = '{4'b1100, 4'b1010, 3'b010, 4'b1000, 4'b1000, 1'b0};
    vecs[5] = '{4'b0101, 4'b0010, 3'b011, 4'b0111, 4'b0000, 1'b0};
    vecs[6] = '{4'b1010, 4'b1010, 3'b111, 4'b0000, 4'b0100, 1'b0};
    vecs[7] = '{4'b0010, 4'b0101, 3'b001, 4'b1101, 4'b1000, 1'b0};
    vecs[8] = '{4'b1000, 4'b0001, 3'b001, 4'b0111, 4'b0011, 1'b0};
    vecs[9] = '{4'b1111, 4'b1111, 3'b110, 4'b0000, 4'b0000, 1'b1};

    #12;
    check("reset_ctl{ready,a,b,op,valid}", 64'({cmd_ready, alu_a, alu_b, alu_op, rsp_valid}),
          64'({1'b1, 4'b0, 4'b0, 3'b0, 1'b0}));
    check("reset_rsp{res,flg,err,fq,cnt}", 64'({rsp_result, rsp_flags, rsp_err, flags_q, op_count}), 64'd0);
    rst_n = 1'b1;
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;

    // Directed vectors, one at a time; first one also checks latency.
    for (int i = 0; i < 10; i++) begin
      send(vecs[i].a, vecs[i].b, vecs[i].op, vecs[i].res, vecs[i].flg, vecs[i].err);
      if (i == 0) begin
        @(negedge clk); check("latency_after_E0", 64'(rsp_valid), 64'd0);
        @(negedge clk); check("latency_after_E1", 64'(rsp_valid), 64'd0);
        @(negedge clk); check("latency_after_E2", 64'(rsp_valid), 64'd1);
      end
      drain(20);
      if (i == 3) check("illegal_keeps_sticky{fq,cnt}", 64'({flags_q, op_count}), 64'({4'b0110, 8'd3}));
    end

    // Backpressure: six back-to-back pushes, only DEPTH+1 fit.
    rsp_ready = 1'b0;
    acc_cnt = 0;
    for (int k = 0; k < 6; k++) begin
      a = 4'($urandom); b = 4'($urandom); op = rand_legal_op();
      model(a, b, op, res, flg, err);
      try_send(a, b, op, res, flg, err, acc);
      acc_cnt += int'(acc);
    end
    check("accepted_under_backpressure", 64'(acc_cnt), 64'(DEPTH + 1));
    @(negedge clk);
    check("cmd_ready_when_full", 64'(cmd_ready), 64'd0);
    repeat (4) @(posedge clk);
    #1;
    retire_cyc.delete();
    rsp_ready = 1'b1;
    drain(40);
    check("retired_after_release", 64'(retire_cyc.size()), 64'(DEPTH + 1));
    for (int k = 1; k < retire_cyc.size(); k++)
      check("retire_spacing", 64'(retire_cyc[k] - retire_cyc[k-1]), 64'd2);

    // Reset while EXEC with three commands still queued.
    rsp_ready = 1'b0;
    send_model(4'h3, 4'h4, 3'b000);
    for (int k = 0; k < 10 && !rsp_valid; k++) @(negedge clk);
    @(posedge clk);
    #1;
    for (int k = 0; k < 4; k++) send_model(4'(k + 1), 4'(k), 3'b001);
    rsp_ready = 1'b1;
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("midreset_ctl{ready,a,b,op,valid}", 64'({cmd_ready, alu_a, alu_b, alu_op, rsp_valid}),
          64'({1'b1, 4'b0, 4'b0, 3'b0, 1'b0}));
    check("midreset_rsp{res,flg,err,fq,cnt}", 64'({rsp_result, rsp_flags, rsp_err, flags_q, op_count}), 64'd0);
    sb.delete();
    m_fq = '0;
    m_cnt = '0;
    #3;
    rst_n = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      check("no_stale_rsp{valid,ready}", 64'({rsp_valid, cmd_ready}), 64'({1'b0, 1'b1}));
    end
    @(posedge clk);
    #1;

    // 260 legal ops: counter wraps through zero.
    for (int k = 0; k < 260; k++) send_model(4'($urandom), 4'($urandom), rand_legal_op());
    drain(100);
    check("op_count_wrap", 64'(op_count), 64'd4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
